// File: rtl/beat_sequencer.sv
// Beat index generator for the tone lookup: play/pause/stop control,
// tempo-selectable beat rate and optional looping over the song length.
module beat_sequencer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BEAT_HZ  = 8,
    parameter int SONG_LEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_pause,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [1:0]  tempo_sel,
    output logic [11:0] ibeatNum,
    output logic        en,
    output logic        beat_tick,
    output logic        done,
    output logic [1:0]  state
);

    localparam int DIV = CLK_HZ / BEAT_HZ;
    localparam int PW  = (DIV < 1) ? 1 : $clog2(2 * DIV);
    localparam int D0  = (2 * DIV < 1) ? 1 : 2 * DIV;
    localparam int D1  = (DIV < 1) ? 1 : DIV;
    localparam int D2  = (DIV / 2 < 1) ? 1 : DIV / 2;
    localparam int D3  = (DIV / 4 < 1) ? 1 : DIV / 4;

    // The divisor is held as its terminal count (divisor-1) so it fits PW bits.
    localparam logic [PW-1:0] L0 = PW'(D0 - 1);
    localparam logic [PW-1:0] L1 = PW'(D1 - 1);
    localparam logic [PW-1:0] L2 = PW'(D2 - 1);
    localparam logic [PW-1:0] L3 = PW'(D3 - 1);
    localparam logic [11:0]   LAST = 12'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [11:0]   beat_q, beat_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [PW-1:0] lim_q, lim_d;
    logic          en_q, en_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    logic [PW-1:0] lim_sel;
    logic          adv;
    logic          at_end;

    always_comb begin
        lim_sel = L1;
        unique case (tempo_sel)
            2'd0: lim_sel = L0;
            2'd1: lim_sel = L1;
            2'd2: lim_sel = L2;
            2'd3: lim_sel = L3;
        endcase
    end

    // Control pulses win over a coincident beat advance.
    assign adv    = (state_q == S_PLAY) && !stop && !play_pause
                    && (pre_q == lim_q);
    assign at_end = (beat_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            pre_q   <= '0;
            lim_q   <= L1;
            en_q    <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pre_q   <= pre_d;
            lim_q   <= lim_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (play_pause && !stop) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (stop)                          state_d = S_IDLE;
                else if (play_pause)               state_d = S_PAUSE;
                else if (adv && at_end && !loop_en) state_d = S_IDLE;
            end
            S_PAUSE: begin
                if (stop)            state_d = S_IDLE;
                else if (play_pause) state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        beat_d = beat_q;
        pre_d  = pre_q;
        lim_d  = lim_q;
        tick_d = 1'b0;
        done_d = 1'b0;
        en_d   = (state_d == S_PLAY);
        if (state_q == S_IDLE && state_d == S_PLAY) begin
            pre_d  = '0;
            beat_d = '0;
            lim_d  = lim_sel;
        end else if (stop && state_q != S_IDLE) begin
            pre_d  = '0;
            beat_d = '0;
        end else if (adv) begin
            pre_d  = '0;
            lim_d  = lim_sel;
            tick_d = 1'b1;
            if (at_end) begin
                beat_d = '0;
                done_d = !loop_en;
            end else begin
                beat_d = beat_q + 12'd1;
            end
        end else if (state_q == S_PLAY && !play_pause) begin
            pre_d = pre_q + 1'b1;
        end
    end

    assign ibeatNum  = beat_q;
    assign en        = en_q;
    assign beat_tick = tick_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: vector table run through a scoreboard queue,
// plus an asynchronous reset sequence in the middle of playback.
module tb_beat_sequencer;

    logic        clk;
    logic        rst;
    logic        play_pause;
    logic        stop;
    logic        loop_en;
    logic [1:0]  tempo_sel;
    logic [11:0] ibeatNum;
    logic        en;
    logic        beat_tick;
    logic        done;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    beat_sequencer #(
        .CLK_HZ  (1000),
        .BEAT_HZ (100),
        .SONG_LEN(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .play_pause(play_pause),
        .stop      (stop),
        .loop_en   (loop_en),
        .tempo_sel (tempo_sel),
        .ibeatNum  (ibeatNum),
        .en        (en),
        .beat_tick (beat_tick),
        .done      (done),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       pp;
        logic       st;
        logic       lp;
        logic [1:0] tp;
        int         n;
        int         beat;
        int         en;
        int         state;
        int         ticks;
        int         dones;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(string nm, logic pp, logic st, logic lp,
                                logic [1:0] tp, int n, int beat, int en_e,
                                int st_e, int ticks, int dones);
        vec_t v;
        v.nm = nm; v.pp = pp; v.st = st; v.lp = lp; v.tp = tp; v.n = n;
        v.beat = beat; v.en = en_e; v.state = st_e;
        v.ticks = ticks; v.dones = dones;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Entered at a falling edge; pulses last one cycle, outputs are
    // sampled on each following falling edge.
    task automatic run(input vec_t v, output int tk, output int dn);
        tk = 0;
        dn = 0;
        loop_en   = v.lp;
        tempo_sel = v.tp;
        for (int i = 0; i < v.n; i++) begin
            play_pause = (i == 0) ? v.pp : 1'b0;
            stop       = (i == 0) ? v.st : 1'b0;
            @(negedge clk);
            tk += int'(beat_tick);
            dn += int'(done);
        end
        play_pause = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        int   tk, dn;
        sb.push_back(v);
        run(v, tk, dn);
        e = sb.pop_front();
        chk({e.nm, ".beat"},  int'(ibeatNum), e.beat);
        chk({e.nm, ".en"},    int'(en),       e.en);
        chk({e.nm, ".state"}, int'(state),    e.state);
        chk({e.nm, ".ticks"}, tk,             e.ticks);
        chk({e.nm, ".dones"}, dn,             e.dones);
    endtask

    initial begin
        rst        = 1'b0;
        play_pause = 1'b0;
        stop       = 1'b0;
        loop_en    = 1'b1;
        tempo_sel  = 2'd1;

        //          name        pp st lp tp   n  beat en st tk dn
        tbl.push_back(mk("start",   1, 0, 1, 1,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("pre9",    0, 0, 1, 1,  9, 0, 1, 1, 0, 0));
        tbl.push_back(mk("adv1",    0, 0, 1, 1,  1, 1, 1, 1, 1, 0));
        tbl.push_back(mk("to7",     0, 0, 1, 1, 60, 7, 1, 1, 6, 0));
        tbl.push_back(mk("wrap",    0, 0, 1, 1, 10, 0, 1, 1, 1, 0));
        tbl.push_back(mk("nl7",     0, 0, 0, 1, 70, 7, 1, 1, 7, 0));
        tbl.push_back(mk("songend", 0, 0, 0, 1, 10, 0, 0, 0, 1, 1));
        tbl.push_back(mk("idle",    0, 0, 0, 1,  5, 0, 0, 0, 0, 0));
        tbl.push_back(mk("play2",   1, 0, 1, 1,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("pre4",    0, 0, 1, 1, 34, 3, 1, 1, 3, 0));
        tbl.push_back(mk("pause",   1, 0, 1, 1, 50, 3, 0, 2, 0, 0));
        tbl.push_back(mk("resume",  1, 0, 1, 1,  6, 3, 1, 1, 0, 0));
        tbl.push_back(mk("adv4",    0, 0, 1, 1,  1, 4, 1, 1, 1, 0));
        tbl.push_back(mk("stop1",   0, 1, 1, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("play3",   1, 0, 1, 1,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("pre2",    0, 0, 1, 1,  2, 0, 1, 1, 0, 0));
        tbl.push_back(mk("tmp4x",   0, 0, 1, 3,  8, 1, 1, 1, 1, 0));
        tbl.push_back(mk("fast1",   0, 0, 1, 3,  2, 2, 1, 1, 1, 0));
        tbl.push_back(mk("fast4",   0, 0, 1, 3,  8, 6, 1, 1, 4, 0));
        tbl.push_back(mk("stop2",   0, 1, 1, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("play4",   1, 0, 1, 1,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("pre29",   0, 0, 1, 1, 29, 2, 1, 1, 2, 0));
        tbl.push_back(mk("ppstop",  1, 1, 1, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("idleboth",1, 1, 1, 1,  2, 0, 0, 0, 0, 0));
        tbl.push_back(mk("idlestop",0, 1, 1, 1,  2, 0, 0, 0, 0, 0));
        tbl.push_back(mk("play5",   1, 0, 1, 0,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("half19",  0, 0, 1, 0, 19, 0, 1, 1, 0, 0));
        tbl.push_back(mk("halfadv", 0, 0, 1, 2,  1, 1, 1, 1, 1, 0));
        tbl.push_back(mk("dbl",     0, 0, 1, 2,  5, 2, 1, 1, 1, 0));
        tbl.push_back(mk("stop3",   0, 1, 1, 1,  1, 0, 0, 0, 0, 0));

        repeat (3) @(negedge clk);
        chk("rst.beat",  int'(ibeatNum),  0);
        chk("rst.en",    int'(en),        0);
        chk("rst.state", int'(state),     0);
        chk("rst.tick",  int'(beat_tick), 0);
        chk("rst.done",  int'(done),      0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) apply(tbl[i]);

        apply(mk("rplay",  1, 0, 1, 1,  1, 0, 1, 1, 0, 0));
        apply(mk("rto5",   0, 0, 1, 1, 55, 5, 1, 1, 5, 0));
        #2;
        rst = 1'b0;
        #1;
        chk("arst.beat",  int'(ibeatNum),  0);
        chk("arst.en",    int'(en),        0);
        chk("arst.state", int'(state),     0);
        chk("arst.tick",  int'(beat_tick), 0);
        chk("arst.done",  int'(done),      0);
        @(negedge clk);
        rst = 1'b1;
        apply(mk("postrst", 0, 0, 1, 1, 20, 0, 0, 0, 0, 0));
        apply(mk("reply",   1, 0, 1, 1,  1, 0, 1, 1, 0, 0));
        apply(mk("readv",   0, 0, 1, 1, 10, 1, 1, 1, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
Upstream stage of the tone-lookup block. It generates the 12-bit beat index `ibeatNum` and the `en` play qualifier that the tone lookup consumes. It provides play/pause/stop control, a selectable tempo and optional looping over a programmable song length. Its outputs feed the tone lookup's `ibeatNum` and `en` inputs directly.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BEAT_HZ, 8: beat-advance rate at 1x tempo.
- SONG_LEN, 64: number of beats in the song; must be in the range 2..4095.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- play_pause, input, 1: one-cycle pulse (already debounced upstream); toggles play/pause, or starts playback from IDLE.
- stop, input, 1: one-cycle pulse; returns to IDLE with the index cleared.
- loop_en, input, 1: 1 = wrap to beat 0 at end of song; 0 = stop at end of song.
- tempo_sel, input, 2: 0 = 0.5x, 1 = 1x, 2 = 2x, 3 = 4x.
- ibeatNum, output, 12: current beat index, registered.
- en, output, 1: 1 while in PLAY, registered.
- beat_tick, output, 1: one-cycle pulse on the cycle ibeatNum changes due to beat advance.
- done, output, 1: one-cycle pulse when a non-looping song ends.
- state, output, 2: 0 = IDLE, 1 = PLAY, 2 = PAUSE (debug/LED use).

Behaviour:
- Reset (rst = 0, async): state = IDLE, ibeatNum = 0, en = 0, beat_tick = 0, done = 0, prescaler = 0, latched divisor = DIV.
- DIV = CLK_HZ / BEAT_HZ (integer). Effective divisor by tempo_sel:
  - 0 → 2×DIV
  - 1 → DIV
  - 2 → DIV/2
  - 3 → DIV/4
  - All values are floored, with a minimum of 1.
- Prescaler width: ceil(log2(2×DIV)) bits. It counts 0..divisor−1 while in PLAY. On reaching divisor−1 it resets to 0 and advances the beat.
- Tempo latching: tempo_sel is sampled into the latched divisor on entry to PLAY from IDLE and on every beat advance. A tempo change mid-beat takes effect at the next beat, never mid-count.
- FSM transitions (stop has priority over play_pause when both are asserted in the same cycle):
  - IDLE + play_pause → PLAY. Prescaler = 0, ibeatNum = 0.
  - PLAY + play_pause → PAUSE. Prescaler and ibeatNum hold.
  - PAUSE + play_pause → PLAY. Prescaler resumes from its held value.
  - PLAY or PAUSE + stop → IDLE. ibeatNum = 0, prescaler = 0.
  - IDLE + stop → no effect.
- Beat advance (PLAY, prescaler == divisor−1):
  - If ibeatNum < SONG_LEN−1: ibeatNum + 1.
  - If ibeatNum == SONG_LEN−1 and loop_en = 1: ibeatNum = 0, stay in PLAY.
  - If ibeatNum == SONG_LEN−1 and loop_en = 0: ibeatNum = 0, state → IDLE, en = 0, done = 1 for one cycle.
  - beat_tick = 1 in the same cycle as the index update, in all three cases.
- A stop or play_pause arriving in the same cycle as a beat advance wins: no advance, no beat_tick, no done.
- Latency:
  - play_pause at cycle N in IDLE → en = 1 at N+1.
  - First advance (ibeatNum = 1) occurs divisor cycles after en rises.
- en equals (state == PLAY) and is updated in the same cycle as the state register.
- loop_en is sampled only at the end-of-song beat.
- ibeatNum never exceeds SONG_LEN−1.

Test Plan:
- CLK_HZ = 1000, BEAT_HZ = 100 (DIV = 10), SONG_LEN = 8, loop_en = 1, tempo_sel = 1. Pulse play_pause → en = 1 next cycle; ibeatNum steps 0→1→…→7→0 every 10 cycles; beat_tick pulses each step; done never asserts.
- Same setup with loop_en = 0 → after ibeatNum = 7 and 10 more cycles: ibeatNum = 0, en = 0, done = 1 for exactly one cycle, state = 0.
- Pause at prescaler = 4, ibeatNum = 3, hold 50 cycles, then resume → ibeatNum stays 3 throughout the pause; advances to 4 exactly 6 cycles after resume.
- Change tempo_sel 1→3 mid-beat at prescaler = 2 → current beat still completes after 10 cycles total; subsequent beats occur every 2 cycles (10/4 floored = 2).
- Assert play_pause and stop together while in PLAY, in the cycle the prescaler hits 9 → state = IDLE, ibeatNum = 0, no beat_tick, en = 0.
- Assert rst low mid-PLAY at ibeatNum = 5 → all outputs go to zero immediately (asynchronously); after rst is released, the block stays in IDLE until play_pause.
